// File: rtl/mem_port_arbiter.sv
// Byte-wide RAM/IO port arbiter between instruction fetch and the MEM stage.
// Splits each request into per-byte RAM cycles and reassembles little-endian read data.
module mem_port_arbiter #(
  parameter bit PRIO_MEM = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_done_o,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic        busy_o,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 8;
  localparam int unsigned CW = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          owner_mem_q, owner_mem_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] nbytes_q, nbytes_d;
  logic [CW-1:0] iss_q, iss_d;
  logic [CW-1:0] cap_cnt_q, cap_cnt_d;
  logic          cap_vld_q, cap_vld_d;
  logic [DW-1:0] data_q, data_d;

  logic [AW-1:0] mem_a_q, mem_a_d;
  logic [BW-1:0] mem_dout_q, mem_dout_d;
  logic          wr_q, wr_d;
  logic          busy_q, busy_d;
  logic          if_done_q, if_done_d;
  logic          mem_done_q, mem_done_d;
  logic [DW-1:0] if_data_q, if_data_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;

  logic          take_mem;

  // Next-state, byte sequencing and registered-output computation
  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    nbytes_d    = nbytes_q;
    iss_d       = iss_q;
    cap_cnt_d   = cap_cnt_q;
    cap_vld_d   = 1'b0;
    data_d      = data_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    mem_a_d     = '0;
    mem_dout_d  = '0;
    wr_d        = 1'b0;
    take_mem    = 1'b0;

    // A byte issued last cycle lands now, even while paused
    if (cap_vld_q) begin
      data_d[{cap_cnt_q[1:0], 3'b000} +: BW] = mem_din;
      cap_cnt_d = cap_cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (rdy_in && (if_req_i || mem_req_i)) begin
          take_mem    = mem_req_i && (!if_req_i || PRIO_MEM);
          owner_mem_d = take_mem;
          we_d        = take_mem && mem_we_i;
          addr_d      = take_mem ? mem_addr_i : if_addr_i;
          wdata_d     = mem_wdata_i;
          nbytes_d    = !take_mem          ? CW'(4) :
                        (mem_size_i == 2'b00) ? CW'(1) :
                        (mem_size_i == 2'b01) ? CW'(2) : CW'(4);
          iss_d       = '0;
          cap_cnt_d   = '0;
          data_d      = '0;
          state_d     = we_d ? S_WRITE : S_READ;
        end
      end
      S_READ: begin
        if (!owner_mem_q && !if_req_i) begin
          state_d = S_IDLE;
        end else begin
          if (rdy_in && (iss_q < nbytes_q)) begin
            iss_d     = iss_q + CW'(1);
            cap_vld_d = 1'b1;
          end
          if (rdy_in && (cap_cnt_d == nbytes_q)) begin
            state_d = S_DONE;
            if (owner_mem_q) begin
              mem_done_d  = 1'b1;
              mem_rdata_d = data_d;
            end else begin
              if_done_d = 1'b1;
              if_data_d = data_d;
            end
          end
        end
      end
      S_WRITE: begin
        if (rdy_in) begin
          iss_d = iss_q + CW'(1);
          if (iss_q == nbytes_q - CW'(1)) begin
            state_d    = S_DONE;
            mem_done_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Port shows the next unissued byte; after the last issue the address is held
    if ((state_d == S_READ) || (state_d == S_WRITE)) begin
      if (iss_d < nbytes_d) begin
        mem_a_d = addr_d + AW'(iss_d);
        if (state_d == S_WRITE) begin
          mem_dout_d = wdata_d[{iss_d[1:0], 3'b000} +: BW];
        end
      end else begin
        mem_a_d = mem_a_q;
      end
      wr_d = (state_d == S_WRITE);
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= S_IDLE;
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      nbytes_q    <= '0;
      iss_q       <= '0;
      cap_cnt_q   <= '0;
      cap_vld_q   <= 1'b0;
      data_q      <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= '0;
      wr_q        <= 1'b0;
      busy_q      <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      nbytes_q    <= nbytes_d;
      iss_q       <= iss_d;
      cap_cnt_q   <= cap_cnt_d;
      cap_vld_q   <= cap_vld_d;
      data_q      <= data_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      wr_q        <= wr_d;
      busy_q      <= busy_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Write strobe drops in the same cycle the core pauses
  assign mem_wr      = wr_q && rdy_in;
  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign busy_o      = busy_q;
  assign if_done_o   = if_done_q;
  assign mem_done_o  = mem_done_q;
  assign if_data_o   = if_data_q;
  assign mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed timing scenarios plus
// randomized transactions checked against a byte-addressed memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        busy;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  int tests = 0;
  int fails = 0;

  logic [7:0]  ram       [logic [31:0]];
  logic [7:0]  model_mem [logic [31:0]];
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];

  mem_port_arbiter #(.PRIO_MEM(1'b1)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_done_o(if_done),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_size_i(mem_size), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
    .busy_o(busy), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function automatic logic [7:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : dflt(a);
  endfunction

  // Little-endian zero-extended load of n bytes from the model memory
  function automatic logic [31:0] model_load(input logic [31:0] a, input int n);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = model_rd(a + 32'(i));
    return r;
  endfunction

  // RAM environment: one-cycle read latency, writes on cycles with mem_wr
  initial forever begin
    @(posedge clk);
    mem_din <= ram_rd(mem_a);
  end

  initial forever begin
    @(negedge clk);
    if (mem_wr === 1'b1) begin
      ram[mem_a] = mem_dout;
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
  end

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a] = d;
    model_mem[a] = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++; if (mem_a !== 32'h0) begin fails++; $display("FAIL reset_mem_a got=%h exp=0", mem_a); end
    tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
    tests++; if (mem_dout !== 8'h0) begin fails++; $display("FAIL reset_mem_dout got=%h exp=0", mem_dout); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if ({if_done, mem_done} !== 2'b00) begin fails++; $display("FAIL reset_done got=%b exp=00", {if_done, mem_done}); end
    tests++; if ({if_data, mem_rdata} !== 64'h0) begin fails++; $display("FAIL reset_data got=%h exp=0", {if_data, mem_rdata}); end
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_if_word_read();
    preload(32'h1000, 8'h78); preload(32'h1001, 8'h56);
    preload(32'h1002, 8'h34); preload(32'h1003, 8'h12);
    next_cycle();
    if_req = 1'b1; if_addr = 32'h1000;
    for (int c = 1; c <= 7; c++) begin
      next_cycle();
      @(negedge clk);
      if (c <= 4) begin
        tests++; if (mem_a !== 32'h1000 + 32'(c - 1)) begin fails++; $display("FAIL t1_addr c=%0d got=%h exp=%h", c, mem_a, 32'h1000 + 32'(c - 1)); end
        tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL t1_wr c=%0d got=%b exp=0", c, mem_wr); end
      end
      if (c == 6) begin
        tests++; if (if_done !== 1'b1) begin fails++; $display("FAIL t1_done c=6 got=%b exp=1", if_done); end
        tests++; if (if_data !== 32'h12345678) begin fails++; $display("FAIL t1_data got=%h exp=12345678", if_data); end
        if_req = 1'b0;
      end else begin
        tests++; if (if_done !== 1'b0) begin fails++; $display("FAIL t1_nodone c=%0d got=%b exp=0", c, if_done); end
      end
    end
  endtask

  task automatic test_priority();
    logic [31:0] exp_if;
    preload(32'h2003, 8'h9C);
    for (int i = 0; i < 4; i++) preload(32'h3000 + 32'(i), 8'($urandom));
    exp_if = model_load(32'h3000, 4);
    next_cycle();
    if_req = 1'b1; if_addr = 32'h3000;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h2003;
    for (int c = 1; c <= 11; c++) begin
      next_cycle();
      @(negedge clk);
      if (c == 1) begin
        tests++; if (mem_a !== 32'h2003) begin fails++; $display("FAIL t2_mem_addr got=%h exp=2003", mem_a); end
      end
      if (c == 3) begin
        tests++; if (mem_done !== 1'b1) begin fails++; $display("FAIL t2_mem_done got=%b exp=1", mem_done); end
        tests++; if (mem_rdata !== 32'h0000009C) begin fails++; $display("FAIL t2_mem_rdata got=%h exp=0000009c", mem_rdata); end
        mem_req = 1'b0;
      end else begin
        tests++; if (mem_done !== 1'b0) begin fails++; $display("FAIL t2_mem_nodone c=%0d got=%b exp=0", c, mem_done); end
      end
      if (c >= 5 && c <= 8) begin
        tests++; if (mem_a !== 32'h3000 + 32'(c - 5)) begin fails++; $display("FAIL t2_if_addr c=%0d got=%h exp=%h", c, mem_a, 32'h3000 + 32'(c - 5)); end
      end
      if (c == 10) begin
        tests++; if (if_done !== 1'b1) begin fails++; $display("FAIL t2_if_done got=%b exp=1", if_done); end
        tests++; if (if_data !== exp_if) begin fails++; $display("FAIL t2_if_data got=%h exp=%h", if_data, exp_if); end
        if_req = 1'b0;
      end else begin
        tests++; if (if_done !== 1'b0) begin fails++; $display("FAIL t2_if_nodone c=%0d got=%b exp=0", c, if_done); end
      end
    end
  endtask

  task automatic test_io_store();
    wlog_a.delete(); wlog_d.delete();
    model_mem[32'h30000] = 8'hAB;
    next_cycle();
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b00; mem_addr = 32'h30000; mem_wdata = 32'h123456AB;
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      @(negedge clk);
      if (c == 1) begin
        tests++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h30000, 8'hAB}) begin fails++; $display("FAIL t3_write got wr=%b a=%h d=%h exp wr=1 a=00030000 d=ab", mem_wr, mem_a, mem_dout); end
      end
      if (c == 2) begin
        tests++; if (mem_done !== 1'b1) begin fails++; $display("FAIL t3_done got=%b exp=1", mem_done); end
        tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL t3_wr_off got=%b exp=0", mem_wr); end
        mem_req = 1'b0;
      end else begin
        tests++; if (mem_done !== 1'b0) begin fails++; $display("FAIL t3_nodone c=%0d got=%b exp=0", c, mem_done); end
      end
    end
    tests++; if (wlog_a.size() != 1) begin fails++; $display("FAIL t3_wcount got=%0d exp=1", wlog_a.size()); end
  endtask

  task automatic test_pause_store();
    logic [31:0] exp_a [4];
    logic [7:0]  exp_d [4];
    exp_a = '{32'h40, 32'h41, 32'h42, 32'h43};
    exp_d = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 4; i++) model_mem[exp_a[i]] = exp_d[i];
    wlog_a.delete(); wlog_d.delete();
    next_cycle();
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h40; mem_wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 8; c++) begin
      next_cycle();
      rdy = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (c == 2 || c == 3) begin
        tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL t4_pause_wr c=%0d got=%b exp=0", c, mem_wr); end
      end
      if (c == 1 || (c >= 4 && c <= 6)) begin
        tests++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, exp_a[c == 1 ? 0 : c - 3], exp_d[c == 1 ? 0 : c - 3]}) begin
          fails++; $display("FAIL t4_byte c=%0d got wr=%b a=%h d=%h exp a=%h d=%h", c, mem_wr, mem_a, mem_dout, exp_a[c == 1 ? 0 : c - 3], exp_d[c == 1 ? 0 : c - 3]);
        end
      end
      if (c == 7) begin
        tests++; if (mem_done !== 1'b1) begin fails++; $display("FAIL t4_done got=%b exp=1", mem_done); end
        mem_req = 1'b0;
      end else begin
        tests++; if (mem_done !== 1'b0) begin fails++; $display("FAIL t4_nodone c=%0d got=%b exp=0", c, mem_done); end
      end
    end
    tests++;
    if (wlog_a.size() != 4) begin
      fails++; $display("FAIL t4_wcount got=%0d exp=4", wlog_a.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (wlog_a[i] !== exp_a[i] || wlog_d[i] !== exp_d[i]) begin
          fails++; $display("FAIL t4_wlog i=%0d got %h/%h exp %h/%h", i, wlog_a[i], wlog_d[i], exp_a[i], exp_d[i]);
        end
    end
  endtask

  task automatic test_if_abort();
    logic [31:0] exp;
    next_cycle();
    if_req = 1'b1; if_addr = 32'h500;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      if (c == 3) if_req = 1'b0;
      @(negedge clk);
      if (c <= 2) begin
        tests++; if (mem_a !== 32'h500 + 32'(c - 1)) begin fails++; $display("FAIL t5_addr c=%0d got=%h exp=%h", c, mem_a, 32'h500 + 32'(c - 1)); end
      end
      if (c >= 4) begin
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL t5_idle c=%0d got busy=%b exp=0", c, busy); end
      end
      tests++; if (if_done !== 1'b0) begin fails++; $display("FAIL t5_nodone c=%0d got=%b exp=0", c, if_done); end
    end
    exp = model_load(32'h600, 2);
    next_cycle();
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b01; mem_addr = 32'h600;
    for (int c = 1; c <= 5; c++) begin
      next_cycle();
      @(negedge clk);
      if (c == 4) begin
        tests++; if (mem_done !== 1'b1) begin fails++; $display("FAIL t5_load_done got=%b exp=1", mem_done); end
        tests++; if (mem_rdata !== exp) begin fails++; $display("FAIL t5_load_data got=%h exp=%h", mem_rdata, exp); end
        mem_req = 1'b0;
      end
      tests++; if (if_done !== 1'b0) begin fails++; $display("FAIL t5_if_quiet c=%0d got=%b exp=0", c, if_done); end
    end
  endtask

  task automatic test_random();
    logic        is_if, we;
    logic [1:0]  sz;
    logic [31:0] a, wd, exp, got_data;
    int          n;
    bit          got;
    for (int t = 0; t < 40; t++) begin
      is_if = 1'($urandom_range(0, 1));
      we    = !is_if && 1'($urandom_range(0, 1));
      sz    = 2'($urandom_range(0, 3));
      a     = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFFD + 32'($urandom_range(0, 2))
                                          : 32'h100 + 32'($urandom_range(0, 63));
      wd    = $urandom;
      n     = is_if ? 4 : (sz == 2'b00 ? 1 : (sz == 2'b01 ? 2 : 4));
      exp   = we ? 32'h0 : model_load(a, n);
      if (we) for (int i = 0; i < n; i++) model_mem[a + 32'(i)] = wd[8*i +: 8];
      wlog_a.delete(); wlog_d.delete();
      next_cycle();
      rdy = ($urandom_range(0, 3) != 0);
      if (is_if) begin
        if_req = 1'b1; if_addr = a;
      end else begin
        mem_req = 1'b1; mem_we = we; mem_size = sz; mem_addr = a; mem_wdata = wd;
      end
      got = 1'b0;
      for (int c = 0; c < 80 && !got; c++) begin
        next_cycle();
        rdy = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (is_if ? mem_done : if_done) begin
          fails++; tests++; $display("FAIL rnd_wrong_done t=%0d c=%0d", t, c);
        end
        if (is_if ? if_done : mem_done) begin
          got = 1'b1;
          if_req = 1'b0; mem_req = 1'b0;
          got_data = is_if ? if_data : mem_rdata;
          if (!we) begin
            tests++; if (got_data !== exp) begin fails++; $display("FAIL rnd_data t=%0d a=%h n=%0d got=%h exp=%h", t, a, n, got_data, exp); end
          end
        end
      end
      tests++; if (!got) begin fails++; $display("FAIL rnd_timeout t=%0d got no done exp done", t); if_req = 1'b0; mem_req = 1'b0; end
      next_cycle();
      rdy = 1'b1;
      @(negedge clk);
      tests++; if ({if_done, mem_done} !== 2'b00) begin fails++; $display("FAIL rnd_pulse t=%0d got=%b exp=00", t, {if_done, mem_done}); end
      tests++;
      if (wlog_a.size() != (we ? n : 0)) begin
        fails++; $display("FAIL rnd_wcount t=%0d got=%0d exp=%0d", t, wlog_a.size(), we ? n : 0);
      end else begin
        for (int i = 0; i < wlog_a.size(); i++)
          if (wlog_a[i] !== a + 32'(i) || wlog_d[i] !== wd[8*i +: 8]) begin
            fails++; $display("FAIL rnd_wlog t=%0d i=%0d got %h/%h exp %h/%h", t, i, wlog_a[i], wlog_d[i], a + 32'(i), wd[8*i +: 8]);
          end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    wlog_a.delete(); wlog_d.delete();
    model_mem[32'h80] = 8'h44;
    next_cycle();
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h80; mem_wdata = 32'h11223344;
    next_cycle();
    @(negedge clk);
    tests++; if (mem_wr !== 1'b1) begin fails++; $display("FAIL t6_first_wr got=%b exp=1", mem_wr); end
    next_cycle();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({mem_a, mem_dout, mem_wr, busy, if_done, mem_done, if_data, mem_rdata} !== 108'h0) begin
      fails++; $display("FAIL t6_async_clear got a=%h d=%h wr=%b busy=%b done=%b%b exp all 0", mem_a, mem_dout, mem_wr, busy, if_done, mem_done);
    end
    mem_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      @(negedge clk);
      tests++; if ({mem_done, busy, mem_wr} !== 3'b000) begin fails++; $display("FAIL t6_held c=%0d got=%b exp=000", c, {mem_done, busy, mem_wr}); end
    end
    next_cycle();
    rst_n = 1'b1;
    exp = model_load(32'h80, 1);
    next_cycle();
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h80;
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      @(negedge clk);
      if (c == 3) begin
        tests++; if (mem_done !== 1'b1) begin fails++; $display("FAIL t6_post_done got=%b exp=1", mem_done); end
        tests++; if (mem_rdata !== exp) begin fails++; $display("FAIL t6_post_data got=%h exp=%h", mem_rdata, exp); end
        mem_req = 1'b0;
      end
    end
    tests++; if (wlog_a.size() != 1) begin fails++; $display("FAIL t6_wcount got=%0d exp=1", wlog_a.size()); end
  endtask

  initial begin
    rdy = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
    test_reset();
    test_if_word_read();
    test_priority();
    test_io_store();
    test_pause_store();
    test_if_abort();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
